// File: rtl/chunked_subtractor_pkg.sv
// Shared definitions for the chunked subtractor: FSM state encoding and chunk-count derivation.
package chunked_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk_of(input int width, input int chunk);
        return width / chunk;
    endfunction

    // The slice counter keeps at least one bit even for a single-chunk configuration
    function automatic int idx_w_of(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunked_subtractor_sub_chunk.sv
// Combinational CHUNK-bit subtract slice: {bout, diff} = x - y - bin.
module sub_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             bin,
    output logic [CHUNK-1:0] diff,
    output logic             bout
);

    logic [CHUNK:0] full;

    // Zero-extended subtraction: any negative result lands with bit CHUNK set
    assign full = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bin};
    assign diff = full[CHUNK-1:0];
    assign bout = full[CHUNK];

endmodule

// File: rtl/chunked_subtractor.sv
// Multi-cycle unsigned subtractor: d = a - b, one CHUNK-bit slice per cycle, borrow in d[WIDTH].
module chunked_subtractor
    import chunked_subtractor_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   d
);

    localparam int NCHUNK = nchunk_of(WIDTH, CHUNK);
    localparam int IDX_W  = idx_w_of(NCHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $fatal(1, "chunked_subtractor: WIDTH must be a multiple of CHUNK");
    end

    state_t state, state_nxt;

    logic [NCHUNK-1:0][CHUNK-1:0] a_q;
    logic [NCHUNK-1:0][CHUNK-1:0] b_q;
    logic [NCHUNK-1:0][CHUNK-1:0] res_q;
    logic                         bout_q;
    logic                         borrow;
    logic [IDX_W-1:0]             idx;

    logic [CHUNK-1:0] diff;
    logic             bout;
    logic             last;

    assign last = (idx == IDX_W'(NCHUNK - 1));

    sub_chunk #(.CHUNK(CHUNK)) u_sub (
        .x    (a_q[idx]),
        .y    (b_q[idx]),
        .bin  (borrow),
        .diff (diff),
        .bout (bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands only need capturing at accept; their contents are don't-care otherwise
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_q <= a;
            b_q <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            borrow <= 1'b0;
            res_q  <= '0;
            bout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        idx    <= '0;
                        borrow <= 1'b0;
                    end
                end
                RUN: begin
                    res_q[idx] <= diff;
                    borrow     <= bout;
                    if (last) begin
                        idx    <= '0;
                        bout_q <= bout;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign d = {bout_q, res_q};

endmodule
